// File: rtl/juego_pkg.sv
// rtl/juego_pkg.sv - shared game-state types and sprite geometry
package juego_pkg;

    typedef enum logic [1:0] {
        INICIO = 2'b00,
        JUEGO  = 2'b01,
        CHOQUE = 2'b10
    } estado_t;

    // Geometry shared with the colour mux; 11 bits so box sums never overflow
    localparam logic [10:0] JUGADOR_Y    = 11'd340;
    localparam logic [10:0] JUGADOR_ALTO = 11'd124;
    localparam logic [10:0] SPRITE_ANCHO = 11'd100;
    localparam logic [10:0] CARRO_ALTO   = 11'd124;
    localparam logic [10:0] CARRIL1_X    = 11'd150;
    localparam logic [10:0] CARRIL2_X    = 11'd400;

    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/control_posiciones_if.sv
// rtl/control_posiciones_if.sv - frame/button inputs and position/score outputs
interface control_posiciones_if;
    logic       frame_tick;
    logic       btn_izq;
    logic       btn_der;
    logic       btn_inicio;
    logic [9:0] posicionJugador;
    logic [9:0] posicionEnemigo1;
    logic [9:0] posicionEnemigo2;
    logic [1:0] estado;
    logic [7:0] puntaje;

    modport master (
        output frame_tick, btn_izq, btn_der, btn_inicio,
        input  posicionJugador, posicionEnemigo1, posicionEnemigo2, estado, puntaje
    );

    modport slave (
        input  frame_tick, btn_izq, btn_der, btn_inicio,
        output posicionJugador, posicionEnemigo1, posicionEnemigo2, estado, puntaje
    );
endinterface

// File: rtl/detector_choque.sv
// rtl/detector_choque.sv - combinational player/enemy box overlap test
module detector_choque
    import juego_pkg::*;
#(
    parameter logic [10:0] CARRIL_X = CARRIL1_X
) (
    input  logic [9:0] jugador_x,
    input  logic [9:0] enemigo_y,
    output logic       choque
);
    logic [10:0] jx;
    logic [10:0] ey;
    logic        solapa_x;
    logic        solapa_y;

    assign jx = ext11(jugador_x);
    assign ey = ext11(enemigo_y);

    // Half-open boxes: touching edges do not count as a hit
    assign solapa_x = (jx < CARRIL_X + SPRITE_ANCHO) && (jx + SPRITE_ANCHO > CARRIL_X);
    assign solapa_y = (ey < JUGADOR_Y + JUGADOR_ALTO) && (ey + CARRO_ALTO > JUGADOR_Y);
    assign choque   = solapa_x && solapa_y;

endmodule

// File: rtl/control_posiciones.sv
// rtl/control_posiciones.sv - per-frame player/enemy positions, collisions and score
module control_posiciones
    import juego_pkg::*;
#(
    parameter int X_INICIO_JUGADOR  = 280,
    parameter int X_MIN             = 100,
    parameter int X_MAX             = 440,
    parameter int VEL_JUGADOR       = 4,
    parameter int VEL_BASE          = 2,
    parameter int VEL_MAX           = 12,
    parameter int Y_LIMITE          = 480,
    parameter int Y_INICIO_ENEMIGO2 = 240
) (
    input logic                 clk,
    input logic                 rst,
    control_posiciones_if.slave bus
);
    localparam logic [9:0]  X_RESET  = 10'(X_INICIO_JUGADOR);
    localparam logic [9:0]  E2_RESET = 10'(Y_INICIO_ENEMIGO2);
    localparam logic [9:0]  XMIN10   = 10'(X_MIN);
    localparam logic [9:0]  XMAX10   = 10'(X_MAX);
    localparam logic [10:0] XMIN11   = 11'(X_MIN);
    localparam logic [10:0] XMAX11   = 11'(X_MAX);
    localparam logic [10:0] VJ11     = 11'(VEL_JUGADOR);
    localparam logic [10:0] VB11     = 11'(VEL_BASE);
    localparam logic [10:0] VM11     = 11'(VEL_MAX);
    localparam logic [10:0] YL11     = 11'(Y_LIMITE);

    estado_t     est;
    logic [9:0]  pj;
    logic [9:0]  pe1;
    logic [9:0]  pe2;
    logic [7:0]  punt;

    logic [10:0] xs;
    logic [9:0]  nx;
    logic [10:0] vel_sum;
    logic [10:0] vel;
    logic [10:0] ny1;
    logic [10:0] ny2;
    logic        wrap1;
    logic        wrap2;
    logic [7:0]  inc;
    logic        choque1;
    logic        choque2;
    logic        choque;

    detector_choque #(.CARRIL_X(CARRIL1_X)) u_choque1 (
        .jugador_x (pj),
        .enemigo_y (pe1),
        .choque    (choque1)
    );

    detector_choque #(.CARRIL_X(CARRIL2_X)) u_choque2 (
        .jugador_x (pj),
        .enemigo_y (pe2),
        .choque    (choque2)
    );

    assign choque = choque1 | choque2;

    always_comb begin
        xs = ext11(pj);
        nx = pj;
        if (bus.btn_izq && !bus.btn_der) begin
            // Compare before subtracting so the left clamp never wraps
            nx = (xs >= XMIN11 + VJ11) ? 10'(xs - VJ11) : XMIN10;
        end else if (bus.btn_der && !bus.btn_izq) begin
            nx = (xs + VJ11 > XMAX11) ? XMAX10 : 10'(xs + VJ11);
        end

        // Speed follows the registered score, so a new speed applies from the next tick
        vel_sum = VB11 + {6'd0, punt[7:3]};
        vel     = (vel_sum > VM11) ? VM11 : vel_sum;

        ny1   = ext11(pe1) + vel;
        ny2   = ext11(pe2) + vel;
        wrap1 = (ny1 >= YL11);
        wrap2 = (ny2 >= YL11);
        inc   = {7'd0, wrap1} + {7'd0, wrap2};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            est  <= INICIO;
            pj   <= X_RESET;
            pe1  <= 10'd0;
            pe2  <= E2_RESET;
            punt <= 8'd0;
        end else begin
            case (est)
                INICIO: begin
                    if (bus.btn_inicio) est <= JUEGO;
                end
                JUEGO: begin
                    if (choque) begin
                        est <= CHOQUE;
                    end else if (bus.frame_tick) begin
                        pj   <= nx;
                        pe1  <= wrap1 ? 10'd0 : ny1[9:0];
                        pe2  <= wrap2 ? 10'd0 : ny2[9:0];
                        punt <= punt + inc;
                    end
                end
                CHOQUE: begin
                    if (bus.btn_inicio) begin
                        est  <= JUEGO;
                        pj   <= X_RESET;
                        pe1  <= 10'd0;
                        pe2  <= E2_RESET;
                        punt <= 8'd0;
                    end
                end
                default: est <= INICIO;
            endcase
        end
    end

    assign bus.posicionJugador  = pj;
    assign bus.posicionEnemigo1 = pe1;
    assign bus.posicionEnemigo2 = pe2;
    assign bus.estado           = est;
    assign bus.puntaje          = punt;

endmodule

// File: tb/tb_control_posiciones.sv
// tb/tb_control_posiciones.sv - directed self-checking bench for control_posiciones
module tb_control_posiciones;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    control_posiciones_if bus ();

    control_posiciones dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int e1, input int e2,
                           input int p, input int st);
        chk({tag, "_x"},  32'(bus.posicionJugador),  32'(x));
        chk({tag, "_e1"}, 32'(bus.posicionEnemigo1), 32'(e1));
        chk({tag, "_e2"}, 32'(bus.posicionEnemigo2), 32'(e2));
        chk({tag, "_p"},  32'(bus.puntaje),          32'(p));
        chk({tag, "_st"}, 32'(bus.estado),           32'(st));
    endtask

    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // frame_tick held for two edges: the second lands on the collision cycle
    task automatic tick_doble();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic pulso_inicio();
        @(negedge clk);
        bus.btn_inicio = 1'b1;
        @(negedge clk);
        bus.btn_inicio = 1'b0;
    endtask

    initial begin
        int  m1, m2, ms, prev1, prev_s, vel, inc, n1, n2, iter;
        bit  w1, done8, done_max, wrapped;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_izq    = 1'b0;
        bus.btn_der    = 1'b0;
        bus.btn_inicio = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("reset", 280, 0, 240, 0, 0);
        rst = 1'b0;

        tick();
        chk_all("tick_inicio", 280, 0, 240, 0, 0);

        pulso_inicio();
        chk_all("start", 280, 0, 240, 0, 1);
        tick();
        chk_all("k1", 280, 2, 242, 0, 1);

        pulso_inicio();
        chk_all("inicio_en_juego", 280, 2, 242, 0, 1);

        ticks(118);
        chk_all("k119", 280, 238, 478, 0, 1);
        tick();
        chk_all("k120_wrap_e2", 280, 240, 0, 1, 1);

        bus.btn_der = 1'b1;
        ticks(40);
        chk("der_clamp", 32'(bus.posicionJugador), 32'd440);
        ticks(10);
        chk("der_hold", 32'(bus.posicionJugador), 32'd440);
        bus.btn_der = 1'b0;
        ticks(20);

        bus.btn_izq = 1'b1;
        ticks(49);
        chk_all("k239", 244, 478, 238, 1, 1);
        tick();
        chk_all("k240_wrap_e1", 240, 0, 240, 2, 1);
        ticks(50);
        chk_all("k290_izq_clamp", 100, 100, 340, 2, 1);

        bus.btn_der = 1'b1;
        ticks(5);
        chk("ambos", 32'(bus.posicionJugador), 32'd100);
        bus.btn_izq = 1'b0;
        ticks(25);
        chk("x200", 32'(bus.posicionJugador), 32'd200);
        bus.btn_der = 1'b0;

        ticks(28);
        chk_all("k348_borde", 200, 216, 456, 2, 1);
        @(negedge clk);
        chk("sin_choque_216", 32'(bus.estado), 32'd1);
        tick();
        chk_all("k349", 200, 218, 458, 2, 1);
        @(negedge clk);
        chk("choque", 32'(bus.estado), 32'd2);
        ticks(3);
        chk_all("congelado", 200, 218, 458, 2, 2);

        pulso_inicio();
        chk_all("reinicio", 280, 0, 240, 0, 1);

        bus.btn_der = 1'b1;
        ticks(5);
        chk_all("b_k5", 300, 10, 250, 0, 1);
        tick_doble();
        chk_all("choque_con_tick", 304, 12, 252, 0, 2);
        bus.btn_der = 1'b0;
        pulso_inicio();
        chk_all("reinicio2", 280, 0, 240, 0, 1);

        m1 = 0; m2 = 240; ms = 0;
        done8 = 1'b0; done_max = 1'b0; wrapped = 1'b0;
        iter = 0;
        while (!wrapped && iter < 12000) begin
            prev1  = m1;
            prev_s = ms;
            vel = 2 + (ms >> 3);
            if (vel > 12) vel = 12;
            inc = 0;
            n1 = m1 + vel;
            n2 = m2 + vel;
            w1 = (n1 >= 480);
            if (w1) begin m1 = 0; inc++; end else m1 = n1;
            if (n2 >= 480) begin m2 = 0; inc++; end else m2 = n2;
            ms = (ms + inc) & 255;
            tick();
            chk_all("barrido", 280, m1, m2, ms, 1);
            if (prev_s == 8 && !done8 && !w1) begin
                chk("paso_con_8", 32'(int'(bus.posicionEnemigo1) - prev1), 32'd3);
                done8 = 1'b1;
            end
            if (prev_s >= 248 && !done_max && !w1) begin
                chk("paso_saturado", 32'(int'(bus.posicionEnemigo1) - prev1), 32'd12);
                done_max = 1'b1;
            end
            if (ms < prev_s) wrapped = 1'b1;
            iter++;
        end
        chk("barrido_termina", 32'(wrapped), 32'd1);
        chk("puntaje_modulo", 32'(bus.puntaje < 8'd2), 32'd1);

        ticks(3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("rst_async", 280, 0, 240, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all("post_rst_tick", 280, 0, 240, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_posiciones.md
Name: control_posiciones

Overview:
Game-state stage directly upstream of the pixel colour mux. Once per video frame it updates the player X position from the buttons and the two enemy Y positions, detects player/enemy collisions and tracks the score. Its three position outputs connect directly to the colour mux position inputs. All outputs are registered and change only on frame ticks or state changes, so the image stays coherent during active video.

Parameters:
X_INICIO_JUGADOR, 280, player sprite left-edge X after reset or restart
X_MIN, 100, minimum player X (left road edge)
X_MAX, 440, maximum player X (right road edge 540 minus sprite width 100)
VEL_JUGADOR, 4, player pixels per frame while a direction button is held
VEL_BASE, 2, initial enemy pixels per frame
VEL_MAX, 12, enemy speed ceiling
Y_LIMITE, 480, enemy Y at or above which the enemy wraps to 0
Y_INICIO_ENEMIGO2, 240, enemy2 Y after reset or restart (stagger)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame from the VGA sync generator, at vertical-blank start
btn_izq  in  1  move left; synchronised and level-sensitive
btn_der  in  1  move right; synchronised and level-sensitive
btn_inicio  in  1  start or restart; single-cycle pulse, already debounced
posicionJugador  out  10  player sprite left-edge X
posicionEnemigo1  out  10  enemy1 top Y (lane X 150..250)
posicionEnemigo2  out  10  enemy2 top Y (lane X 400..500)
estado  out  2  00 INICIO, 01 JUEGO, 10 CHOQUE
puntaje  out  8  count of enemy wraps, modulo 256

Behaviour:
- Reset (async, rst=1):
  - estado=INICIO, puntaje=0.
  - posicionJugador=X_INICIO_JUGADOR, posicionEnemigo1=0, posicionEnemigo2=Y_INICIO_ENEMIGO2.
- FSM:
  - INICIO: btn_inicio -> JUEGO. Positions hold.
  - JUEGO: collision -> CHOQUE. Otherwise each frame_tick performs one update.
  - CHOQUE: all outputs frozen. btn_inicio reloads reset positions, sets puntaje=0 and goes to JUEGO in the same edge.
- Update (JUEGO, frame_tick=1, no collision this cycle); all results visible one cycle after the tick edge:
  - Player:
    - only btn_izq: X = max(X - VEL_JUGADOR, X_MIN).
    - only btn_der: X = min(X + VEL_JUGADOR, X_MAX).
    - both or neither: hold.
    - Clamp is computed in 11 bits, with no underflow wrap.
  - Enemies: ny = Y + vel, computed in 11 bits.
    - If ny >= Y_LIMITE: Y = 0 and puntaje increments.
    - If both enemies wrap on the same tick, puntaje += 2.
  - Enemy speed: vel = min(VEL_BASE + puntaje[7:3], VEL_MAX). It is combinational from the registered puntaje, so a new speed applies from the next tick.
- Collision:
  - Evaluated every cycle in JUEGO from the registered positions, using 11-bit sums.
  - Player box: X in [pJ, pJ+100), Y in [340, 464).
  - Enemy1 box: X [150, 250), Y [pE1, pE1+124). Enemy2 box: X [400, 500), Y [pE2, pE2+124).
  - Overlap on both axes with either enemy -> CHOQUE at the next edge.
  - Collision and frame_tick in the same cycle: collision wins and positions do not update.
- Events outside JUEGO:
  - frame_tick in INICIO or CHOQUE is ignored.
  - btn_inicio in JUEGO is ignored.
- rst asserted mid-frame returns to the reset values immediately, regardless of state.
- No other output ever changes between frame ticks except on an FSM transition.

Decomposition:
- Package juego_pkg holds:
  - the estado_t enum (INICIO, JUEGO, CHOQUE);
  - constants JUGADOR_Y=340, JUGADOR_ALTO=124, SPRITE_ANCHO=100, CARRO_ALTO=124, CARRIL1_X=150, CARRIL2_X=400.
- The colour mux shares these constants.
- One sub-module, detector_choque: purely combinational box-overlap test. Instantiated twice, once per enemy.

Test Plan:
- Reset, then btn_inicio, then 1 tick -> estado=01, posicionEnemigo1=2, posicionEnemigo2=242, posicionJugador=280.
- btn_der held for 50 ticks from 280 (enemies kept clear) -> X=440 clamped, stays 440. btn_izq held for 100 ticks -> X=100. Both buttons held -> X unchanged.
- Enemy1 at 478, vel=2, tick -> posicionEnemigo1=0, puntaje+1. Force puntaje 7->8 -> next tick's step is 3. With puntaje=255 -> vel=12 saturated, and the next wrap makes puntaje=0.
- Player X=200 while enemy1 Y reaches 220 (overlap) -> estado=10 one edge later. Further ticks leave every output frozen. btn_inicio -> positions 280/0/240, puntaje=0, estado=01.
- Collision condition and frame_tick in the same cycle -> CHOQUE, positions are the pre-tick values.
- rst pulse mid-game between ticks -> all outputs at reset values asynchronously, estado=00.
